// File: rtl/turn_controller_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package turn_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_A_WAIT   = 3'd2,
        ST_A_SETTLE = 3'd3,
        ST_B_WAIT   = 3'd4,
        ST_B_SETTLE = 3'd5,
        ST_OVER     = 3'd6
    } state_e;

    localparam int GRID_B_OFS = 9;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_A    = 2'b01;
    localparam logic [1:0] WINNER_B    = 2'b10;

    // rows, columns, diagonals; bit n = cell n
    localparam logic [7:0][8:0] WIN_LINES = {
        9'h007, 9'h038, 9'h1C0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };

    function automatic logic cell_free(input logic [17:0] grid, input logic [3:0] p);
        logic [8:0] occ;
        occ = grid[8:0] | grid[GRID_B_OFS +: 9];
        return (p <= 4'd8) && (((occ >> p) & 9'd1) == 9'd0);
    endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Player-input / recorder-side signal bundle for turn_controller.
interface turn_controller_if;
    logic        start;
    logic        a_req;
    logic [3:0]  a_pos;
    logic        b_req;
    logic [3:0]  b_pos;
    logic [17:0] game_grid;
    logic        board_rst_n;
    logic [3:0]  pos;
    logic        player_a_move;
    logic        player_b_move;
    logic        game_state;
    logic        turn;
    logic [1:0]  winner;
    logic        illegal;
    logic        turn_skipped;

    modport slave (
        input  start, a_req, a_pos, b_req, b_pos, game_grid,
        output board_rst_n, pos, player_a_move, player_b_move,
               game_state, turn, winner, illegal, turn_skipped
    );

    modport master (
        output start, a_req, a_pos, b_req, b_pos, game_grid,
        input  board_rst_n, pos, player_a_move, player_b_move,
               game_state, turn, winner, illegal, turn_skipped
    );
endinterface

// File: rtl/turn_controller_line_checker.sv
// Flags a completed line (row, column or diagonal) in one player's 9-bit plane.
module turn_controller_line_checker
    import turn_controller_pkg::*;
(
    input  logic [8:0] plane,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((plane & WIN_LINES[i]) == WIN_LINES[i]) win = 1'b1;
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer for disappearing-mark tic-tac-toe: validation, move strobes,
// win detection and per-turn timeout.
module turn_controller
    import turn_controller_pkg::*;
#(
    parameter int TURN_TIMEOUT = 100_000_000,
    parameter int TO_W         = 27
) (
    input  logic              clk,
    input  logic              reset,
    turn_controller_if.slave  bus
);

    // state    | meaning
    // IDLE     | after reset, waiting for start
    // CLEAR    | board clear pulse to recorder
    // A_WAIT   | waiting for a legal request from A
    // A_SETTLE | A strobe issued, waiting for recorder, then win check
    // B_WAIT   | waiting for a legal request from B
    // B_SETTLE | B strobe issued, waiting for recorder, then win check
    // OVER     | game decided, winner held until start

    localparam logic [TO_W-1:0] T_LAST = TO_W'(TURN_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [3:0]      pos_q, pos_d;
    logic            a_move_q, a_move_d;
    logic            b_move_q, b_move_d;
    logic            game_state_q, game_state_d;
    logic            turn_q, turn_d;
    logic [1:0]      winner_q, winner_d;
    logic            illegal_q, illegal_d;
    logic            skip_q, skip_d;
    logic            brst_n_q, brst_n_d;

    logic [8:0] mover_plane;
    logic       mover_win;

    // SETTLE only ever checks the mover, whose identity is still held in turn_q
    assign mover_plane = turn_q ? bus.game_grid[GRID_B_OFS +: 9] : bus.game_grid[8:0];

    turn_controller_line_checker u_line_checker (
        .plane (mover_plane),
        .win   (mover_win)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = (timer_q == T_LAST) ? timer_q : timer_q + TO_W'(1);
        pos_d        = pos_q;
        a_move_d     = 1'b0;
        b_move_d     = 1'b0;
        game_state_d = game_state_q;
        turn_d       = turn_q;
        winner_d     = winner_q;
        illegal_d    = 1'b0;
        skip_d       = 1'b0;
        brst_n_d     = 1'b1;

        if (bus.start) begin
            state_d  = ST_CLEAR;
            brst_n_d = 1'b0;
            winner_d = WINNER_NONE;
            turn_d   = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    state_d      = ST_A_WAIT;
                    game_state_d = 1'b1;
                end
                ST_A_WAIT: begin
                    if (bus.a_req && cell_free(bus.game_grid, bus.a_pos)) begin
                        pos_d    = bus.a_pos;
                        a_move_d = 1'b1;
                        state_d  = ST_A_SETTLE;
                    end else begin
                        illegal_d = bus.a_req;
                        if (timer_q == T_LAST) begin
                            skip_d  = 1'b1;
                            turn_d  = 1'b1;
                            state_d = ST_B_WAIT;
                        end
                    end
                end
                ST_B_WAIT: begin
                    if (bus.b_req && cell_free(bus.game_grid, bus.b_pos)) begin
                        pos_d    = bus.b_pos;
                        b_move_d = 1'b1;
                        state_d  = ST_B_SETTLE;
                    end else begin
                        illegal_d = bus.b_req;
                        if (timer_q == T_LAST) begin
                            skip_d  = 1'b1;
                            turn_d  = 1'b0;
                            state_d = ST_A_WAIT;
                        end
                    end
                end
                ST_A_SETTLE, ST_B_SETTLE: begin
                    // timer==1 marks the second settle cycle; grid now holds the new mark
                    if (timer_q == TO_W'(1)) begin
                        if (mover_win) begin
                            winner_d     = turn_q ? WINNER_B : WINNER_A;
                            game_state_d = 1'b0;
                            state_d      = ST_OVER;
                        end else begin
                            turn_d  = ~turn_q;
                            state_d = turn_q ? ST_A_WAIT : ST_B_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            pos_q        <= 4'd0;
            a_move_q     <= 1'b0;
            b_move_q     <= 1'b0;
            game_state_q <= 1'b0;
            turn_q       <= 1'b0;
            winner_q     <= WINNER_NONE;
            illegal_q    <= 1'b0;
            skip_q       <= 1'b0;
            brst_n_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pos_q        <= pos_d;
            a_move_q     <= a_move_d;
            b_move_q     <= b_move_d;
            game_state_q <= game_state_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            illegal_q    <= illegal_d;
            skip_q       <= skip_d;
            brst_n_q     <= brst_n_d;
        end
    end

    assign bus.board_rst_n   = brst_n_q;
    assign bus.pos           = pos_q;
    assign bus.player_a_move = a_move_q;
    assign bus.player_b_move = b_move_q;
    assign bus.game_state    = game_state_q;
    assign bus.turn          = turn_q;
    assign bus.winner        = winner_q;
    assign bus.illegal       = illegal_q;
    assign bus.turn_skipped  = skip_q;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with a minimal behavioural mark recorder.
module tb_turn_controller;

    logic        clk;
    logic        reset;
    logic [17:0] grid;
    int          total;
    int          bad;

    turn_controller_if bus ();

    turn_controller #(.TURN_TIMEOUT(8), .TO_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // recorder stand-in: marks land one edge after the strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) grid <= '0;
        else if (!bus.board_rst_n) grid <= '0;
        else begin
            if (bus.player_a_move) grid[bus.pos] <= 1'b1;
            if (bus.player_b_move) grid[9 + bus.pos] <= 1'b1;
        end
    end
    assign bus.game_grid = grid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pos"},     32'(bus.pos), 0);
        chk({tag, "_amove"},   32'(bus.player_a_move), 0);
        chk({tag, "_bmove"},   32'(bus.player_b_move), 0);
        chk({tag, "_gstate"},  32'(bus.game_state), 0);
        chk({tag, "_turn"},    32'(bus.turn), 0);
        chk({tag, "_winner"},  32'(bus.winner), 0);
        chk({tag, "_illegal"}, 32'(bus.illegal), 0);
        chk({tag, "_skip"},    32'(bus.turn_skipped), 0);
        chk({tag, "_brst"},    32'(bus.board_rst_n), 1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.a_req = 1'b0;
        bus.a_pos = 4'd0;
        bus.b_req = 1'b0;
        bus.b_pos = 4'd0;
        cyc(2);
        chk_reset_vals("rst");
        reset = 1'b1;
        cyc(1);

        // start, then A takes the centre
        bus.start = 1'b1;
        cyc(1); bus.start = 1'b0;
        chk("clear_brst", 32'(bus.board_rst_n), 0);
        cyc(1);
        chk("clear_brst_hi", 32'(bus.board_rst_n), 1);
        chk("start_gstate", 32'(bus.game_state), 1);
        chk("start_turn", 32'(bus.turn), 0);
        bus.a_req = 1'b1; bus.a_pos = 4'd4;
        cyc(1); bus.a_req = 1'b0;
        chk("a4_strobe", 32'(bus.player_a_move), 1);
        chk("a4_pos", 32'(bus.pos), 4);
        chk("a4_nob", 32'(bus.player_b_move), 0);
        cyc(1);
        chk("a4_grid", 32'(grid[4]), 1);
        chk("a4_strobe_1cyc", 32'(bus.player_a_move), 0);
        chk("a4_turn_settle", 32'(bus.turn), 0);
        cyc(1);
        chk("a4_turn_after", 32'(bus.turn), 1);

        // B: occupied, out of range, then legal
        bus.b_req = 1'b1; bus.b_pos = 4'd4;
        cyc(1);
        chk("b4_illegal", 32'(bus.illegal), 1);
        chk("b4_nostrobe", 32'(bus.player_b_move), 0);
        chk("b4_turn", 32'(bus.turn), 1);
        bus.b_pos = 4'd9;
        cyc(1);
        chk("b9_illegal", 32'(bus.illegal), 1);
        chk("b9_nostrobe", 32'(bus.player_b_move), 0);
        bus.b_pos = 4'd0;
        cyc(1); bus.b_req = 1'b0;
        chk("b0_strobe", 32'(bus.player_b_move), 1);
        chk("b0_pos", 32'(bus.pos), 0);
        chk("b0_legal", 32'(bus.illegal), 0);
        cyc(2);
        chk("b0_turn_after", 32'(bus.turn), 0);

        // both requests in A_WAIT: only A moves, no illegal
        bus.a_req = 1'b1; bus.a_pos = 4'd1;
        bus.b_req = 1'b1; bus.b_pos = 4'd2;
        cyc(1); bus.a_req = 1'b0; bus.b_req = 1'b0;
        chk("both_amove", 32'(bus.player_a_move), 1);
        chk("both_bmove", 32'(bus.player_b_move), 0);
        chk("both_illegal", 32'(bus.illegal), 0);
        chk("both_pos", 32'(bus.pos), 1);
        cyc(2);
        chk("a1_turn_after", 32'(bus.turn), 1);
        bus.b_req = 1'b1; bus.b_pos = 4'd3;
        cyc(1); bus.b_req = 1'b0;
        chk("b3_strobe", 32'(bus.player_b_move), 1);
        cyc(2);

        // A completes column 1-4-7
        bus.a_req = 1'b1; bus.a_pos = 4'd7;
        cyc(1); bus.a_req = 1'b0;
        chk("a7_strobe", 32'(bus.player_a_move), 1);
        chk("a7_pos", 32'(bus.pos), 7);
        cyc(1);
        chk("win_not_yet", 32'(bus.winner), 0);
        cyc(1);
        chk("win_a", 32'(bus.winner), 1);
        chk("win_gstate", 32'(bus.game_state), 0);
        chk("win_turn", 32'(bus.turn), 0);
        bus.a_req = 1'b1; bus.a_pos = 4'd8;
        bus.b_req = 1'b1; bus.b_pos = 4'd8;
        cyc(1); bus.a_req = 1'b0; bus.b_req = 1'b0;
        chk("over_noa", 32'(bus.player_a_move), 0);
        chk("over_nob", 32'(bus.player_b_move), 0);
        chk("over_noillegal", 32'(bus.illegal), 0);
        cyc(10);
        chk("over_hold_winner", 32'(bus.winner), 1);
        chk("over_noskip", 32'(bus.turn_skipped), 0);

        // timeout: A then B skipped
        bus.start = 1'b1;
        cyc(1); bus.start = 1'b0;
        chk("restart_brst", 32'(bus.board_rst_n), 0);
        cyc(1);
        chk("restart_grid", 32'(grid), 0);
        chk("restart_winner", 32'(bus.winner), 0);
        chk("restart_turn", 32'(bus.turn), 0);
        chk("restart_gstate", 32'(bus.game_state), 1);
        cyc(7);
        chk("to_a_early", 32'(bus.turn_skipped), 0);
        chk("to_a_early_turn", 32'(bus.turn), 0);
        cyc(1);
        chk("to_a_skip", 32'(bus.turn_skipped), 1);
        chk("to_a_turn", 32'(bus.turn), 1);
        cyc(1);
        chk("to_a_pulse", 32'(bus.turn_skipped), 0);
        cyc(7);
        chk("to_b_skip", 32'(bus.turn_skipped), 1);
        chk("to_b_turn", 32'(bus.turn), 0);
        cyc(7);
        bus.a_req = 1'b1; bus.a_pos = 4'd4;
        cyc(1); bus.a_req = 1'b0;
        chk("to_race_move", 32'(bus.player_a_move), 1);
        chk("to_race_noskip", 32'(bus.turn_skipped), 0);
        chk("to_race_pos", 32'(bus.pos), 4);
        cyc(2);
        chk("to_race_turn", 32'(bus.turn), 1);

        // reset during A_SETTLE
        bus.b_req = 1'b1; bus.b_pos = 4'd0;
        cyc(1); bus.b_req = 1'b0;
        chk("b0b_strobe", 32'(bus.player_b_move), 1);
        cyc(2);
        bus.a_req = 1'b1; bus.a_pos = 4'd8;
        cyc(1); bus.a_req = 1'b0;
        chk("a8_strobe", 32'(bus.player_a_move), 1);
        reset = 1'b0;
        cyc(1);
        chk_reset_vals("midrst");
        cyc(1);
        reset = 1'b1;
        cyc(3);
        chk_reset_vals("postrst");

        // start during a settle clears the board
        bus.start = 1'b1;
        cyc(1); bus.start = 1'b0;
        cyc(1);
        chk("s2_gstate", 32'(bus.game_state), 1);
        bus.a_req = 1'b1; bus.a_pos = 4'd2;
        cyc(1); bus.a_req = 1'b0;
        chk("s2_a2_strobe", 32'(bus.player_a_move), 1);
        bus.start = 1'b1;
        cyc(1); bus.start = 1'b0;
        chk("s2_nostrobe", 32'(bus.player_a_move), 0);
        chk("s2_brst", 32'(bus.board_rst_n), 0);
        cyc(1);
        chk("s2_grid", 32'(grid), 0);
        chk("s2_winner", 32'(bus.winner), 0);
        chk("s2_turn", 32'(bus.turn), 0);
        chk("s2_gstate2", 32'(bus.game_state), 1);
        bus.a_req = 1'b1; bus.a_pos = 4'd2;
        cyc(1); bus.a_req = 1'b0;
        chk("s2_replay_strobe", 32'(bus.player_a_move), 1);
        chk("s2_replay_pos", 32'(bus.pos), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
